// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential SRAM reads with one-cycle latency,
// a small {addr, data} FIFO toward decode, and a redirect that flushes everything.
module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 20,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned            DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o
);

  localparam int unsigned    PW        = $clog2(DEPTH);
  localparam int unsigned    CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  pop;
  logic                  push;
  logic [CW:0]           occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign instr_valid_o = (count_q != '0) & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign push          = inflight_q & ~redirect_i;
  // Credit: entries held plus the read in flight, minus what leaves this cycle.
  assign occ           = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign mem_req_o     = rstn & ~redirect_i & (occ < DEPTH_OCC);
  assign mem_addr_o    = pc_q;
  assign instr_o       = data_mem[rd_ptr_q];
  assign instr_addr_o  = addr_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q            <= RESET_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_addr_i;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= mem_req_o;
      if (mem_req_o) begin
        pc_q            <= pc_q + ADDR_WIDTH'(1);
        inflight_addr_q <= pc_q;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so an empty FIFO reads back zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr_q] <= inflight_addr_q;
      data_mem[wr_ptr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a queue scoreboard over random
// ready/redirect traffic, and an address-wrap check on a second instance.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_fn(input logic [19:0] a);
    return {a[11:0], a} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT 0: default parameters ----------------
  logic        rstn = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [19:0] raddr = '0;
  logic        mem_req, valid;
  logic [19:0] maddr, iaddr;
  logic [31:0] rdata = '0, instr;

  fetch_unit #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .RESET_ADDR(20'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .mem_req_o(mem_req), .mem_addr_o(maddr),
    .mem_rdata_i(rdata), .redirect_i(redirect), .redirect_addr_i(raddr),
    .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr), .instr_addr_o(iaddr)
  );

  always @(posedge clk) rdata <= mem_fn(maddr);

  // ---------------- DUT 1: reset address near the top ----------------
  logic        rstn1 = 1'b0, redirect1 = 1'b0, ready1 = 1'b1;
  logic [19:0] raddr1 = '0;
  logic        mem_req1, valid1;
  logic [19:0] maddr1, iaddr1;
  logic [31:0] rdata1 = '0, instr1;

  fetch_unit #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .RESET_ADDR(20'hFFFFE), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rstn(rstn1), .mem_req_o(mem_req1), .mem_addr_o(maddr1),
    .mem_rdata_i(rdata1), .redirect_i(redirect1), .redirect_addr_i(raddr1),
    .instr_valid_o(valid1), .instr_ready_i(ready1), .instr_o(instr1), .instr_addr_o(iaddr1)
  );

  always @(posedge clk) rdata1 <= mem_fn(maddr1);

  // ---------------- Scoreboard: expected addresses queued at issue ----------------
  logic [19:0] sb[$];
  logic [19:0] exp_pc = '0;
  logic        inflight_m = 1'b0;

  always @(negedge clk) begin
    int          fifo_cnt;
    logic        exp_valid, exp_req, p;
    logic [19:0] e;
    if (!rstn) begin
      check("sb req in reset", 32'(mem_req), 32'h0);
      sb.delete();
      exp_pc     = '0;
      inflight_m = 1'b0;
    end else if (redirect) begin
      check("sb valid in redirect", 32'(valid), 32'h0);
      check("sb req in redirect", 32'(mem_req), 32'h0);
      sb.delete();
      exp_pc     = raddr;
      inflight_m = 1'b0;
    end else begin
      fifo_cnt  = sb.size() - int'(inflight_m);
      exp_valid = (fifo_cnt != 0);
      p         = exp_valid & ready;
      exp_req   = (sb.size() - int'(p)) < DEPTH;
      check("sb valid", 32'(valid), 32'(exp_valid));
      check("sb req", 32'(mem_req), 32'(exp_req));
      check("sb mem_addr", 32'(maddr), 32'(exp_pc));
      if (p) begin
        e = sb.pop_front();
        check("sb instr_addr", 32'(iaddr), 32'(e));
        check("sb instr", instr, mem_fn(e));
      end
      if (exp_req) begin
        sb.push_back(exp_pc);
        exp_pc = exp_pc + 20'd1;
      end
      inflight_m = exp_req;
    end
  end

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic        rstn, ready, redir;
    logic [19:0] raddr;
    logic        req;
    logic [19:0] maddr;
    logic        valid;
    logic [19:0] iaddr;
    logic        zchk;   // outputs must read zero (storage freshly reset)
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rs, input logic rd, input logic rdr, input logic [19:0] ra,
                             input logic rq, input logic [19:0] ma, input logic vl,
                             input logic [19:0] ia, input logic z);
    vec_t t;
    t.rstn = rs; t.ready = rd; t.redir = rdr; t.raddr = ra;
    t.req = rq; t.maddr = ma; t.valid = vl; t.iaddr = ia; t.zchk = z;
    return t;
  endfunction

  initial begin
    logic [19:0] base;
    logic [19:0] ea;

    // Reset release with ready=1: addresses issue back to back, data two cycles behind.
    tbl.push_back(v(1,1,0,0,     1,20'h0,   0,20'h0, 1));
    tbl.push_back(v(1,1,0,0,     1,20'h1,   0,20'h0, 1));
    tbl.push_back(v(1,1,0,0,     1,20'h2,   1,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h3,   1,20'h1, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h4,   1,20'h2, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h5,   1,20'h3, 0));
    // One-cycle reset pulse with the FIFO occupied.
    tbl.push_back(v(0,0,0,0,     0,20'h6,   1,20'h4, 0));
    // Back to reset values, then backpressure: exactly two requests.
    tbl.push_back(v(1,0,0,0,     1,20'h0,   0,20'h0, 1));
    tbl.push_back(v(1,0,0,0,     1,20'h1,   0,20'h0, 1));
    for (int k = 0; k < 8; k++)
      tbl.push_back(v(1,0,0,0,   0,20'h2,   1,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h2,   1,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h3,   1,20'h1, 0));
    // Redirect with 0x2 in the FIFO and 0x3 in flight.
    tbl.push_back(v(1,1,1,20'h100, 0,20'h4, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h100, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h101, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h102, 1,20'h100, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h103, 1,20'h101, 0));
    // Back-to-back redirects: the second target wins.
    tbl.push_back(v(1,1,1,20'h200, 0,20'h104, 0,20'h0, 0));
    tbl.push_back(v(1,1,1,20'h300, 0,20'h200, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h300, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h301, 0,20'h0, 0));
    tbl.push_back(v(1,1,0,0,     1,20'h302, 1,20'h300, 0));

    repeat (3) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; ready = tbl[i].ready; redirect = tbl[i].redir; raddr = tbl[i].raddr;
      @(negedge clk);
      check($sformatf("row%0d req", i), 32'(mem_req), 32'(tbl[i].req));
      check($sformatf("row%0d mem_addr", i), 32'(maddr), 32'(tbl[i].maddr));
      check($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("row%0d instr_addr", i), 32'(iaddr), 32'(tbl[i].iaddr));
        check($sformatf("row%0d instr", i), instr, mem_fn(tbl[i].iaddr));
      end else if (tbl[i].zchk) begin
        check($sformatf("row%0d instr_addr zero", i), 32'(iaddr), 32'h0);
        check($sformatf("row%0d instr zero", i), instr, 32'h0);
      end
      @(posedge clk);
      #1;
    end

    // Random ready with occasional redirects; the scoreboard does the checking.
    for (int c = 0; c < 1000; c++) begin
      rstn     = 1'b1;
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 49) == 0);
      raddr    = ($urandom_range(0, 1) != 0) ? (20'hFFFF8 | 20'($urandom_range(0, 7))) : 20'($urandom);
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;
    ready    = 1'b0;

    // Wrap from 0xFFFFE through zero on the second instance.
    rstn1 = 1'b1;
    base  = 20'hFFFFE;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ea = base + 20'(k);
      check($sformatf("wrap%0d req", k), 32'(mem_req1), 32'h1);
      check($sformatf("wrap%0d mem_addr", k), 32'(maddr1), 32'(ea));
      check($sformatf("wrap%0d valid", k), 32'(valid1), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2) begin
        ea = base + 20'(k - 2);
        check($sformatf("wrap%0d instr_addr", k), 32'(iaddr1), 32'(ea));
        check($sformatf("wrap%0d instr", k), instr1, mem_fn(ea));
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
